// File: rtl/rvnova_pkg.sv
// rtl/rvnova_pkg.sv - shared core widths and writeback requester indices
package rvnova_pkg;

  localparam int XLEN          = 32;
  localparam int AW            = 5;
  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_REQ       = 3;

  // Writeback requester slots on the shared regfile port
  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;
  localparam int REQ_MD  = 2;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback/issue/regfile bundle for the wb arbiter
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = rvnova_pkg::NUM_REQ,
  parameter int XLEN    = rvnova_pkg::XLEN,
  parameter int AW      = rvnova_pkg::AW
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*AW-1:0]   req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    issue_valid;
  logic [AW-1:0]           issue_rd;
  logic [AW-1:0]           rs1_addr;
  logic [AW-1:0]           rs2_addr;
  logic                    stall;
  logic                    rf_we;
  logic [AW-1:0]           rf_rd_addr;
  logic [XLEN-1:0]         rf_w_data;
  logic                    fwd1_valid;
  logic [XLEN-1:0]         fwd1_data;
  logic                    fwd2_valid;
  logic [XLEN-1:0]         fwd2_data;

  // Producers and decode drive requests/issue; they observe grants, stall and the write port
  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  req_ready, stall, rf_we, rf_rd_addr, rf_w_data,
           fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );

  // The arbiter consumes requests/issue and owns grants, stall and the write port
  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
    output req_ready, stall, rf_we, rf_rd_addr, rf_w_data,
           fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with self-advancing pointer
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;
  logic          found;

  // First requester at or after the pointer wins; pointer moves just past the winner
  always_comb begin
    gnt   = '0;
    ptr_n = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          ptr_n  = (i == N - 1) ? '0 : PW'(i + 1);
        end
      end
    end
    if (!reset) begin
      gnt   = '0;
      ptr_n = ptr;
    end
  end

  // Pointer register; holds when nothing is granted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_n;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter, pending-write scoreboard, optional WB_BYPASS_EN forwarding
module regfile_wb_arbiter #(
  parameter int NUM_REQ = rvnova_pkg::NUM_REQ,
  parameter int XLEN    = rvnova_pkg::XLEN,
  parameter int AW      = rvnova_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int NREG = 2 ** AW;

  logic [NUM_REQ-1:0] gnt;
  logic               g_any;
  logic [AW-1:0]      g_rd;
  logic [XLEN-1:0]    g_data;
  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [XLEN-1:0]    data_q;
  logic [NREG-1:0]    pend;
  logic [NREG-1:0]    pend_n;
  logic               byp1;
  logic               byp2;
  logic               hz1;
  logic               hz2;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req_valid),
    .gnt   (gnt)
  );

  assign bus.req_ready = gnt;

  // Steer the granted requester's destination and result onto the write stage input
  always_comb begin
    g_any  = |gnt;
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        g_rd   = bus.req_rd[i*AW +: AW];
        g_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Registered write stage; a granted x0 result is swallowed without a write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= g_any && (g_rd != '0);
      if (g_any) begin
        addr_q <= g_rd;
        data_q <= g_data;
      end
    end
  end

  assign bus.rf_we      = we_q;
  assign bus.rf_rd_addr = addr_q;
  assign bus.rf_w_data  = data_q;

  // Next scoreboard: retire the write, then mark the new issue so a newer producer wins
  always_comb begin
    pend_n = pend;
    if (we_q) begin
      pend_n[addr_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != '0)) begin
      pend_n[bus.issue_rd] = 1'b1;
    end
    pend_n[0] = 1'b0;
  end

  // Pending-write scoreboard register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else begin
      pend <= pend_n;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp1          = we_q && (addr_q == bus.rs1_addr) && (bus.rs1_addr != '0);
  assign byp2          = we_q && (addr_q == bus.rs2_addr) && (bus.rs2_addr != '0);
  assign bus.fwd1_data = byp1 ? data_q : '0;
  assign bus.fwd2_data = byp2 ? data_q : '0;
`else
  assign byp1          = 1'b0;
  assign byp2          = 1'b0;
  assign bus.fwd1_data = '0;
  assign bus.fwd2_data = '0;
`endif

  assign bus.fwd1_valid = byp1;
  assign bus.fwd2_valid = byp2;

  // An operand hazards only if still pending and not being forwarded this cycle
  assign hz1       = pend[bus.rs1_addr] & ~byp1;
  assign hz2       = pend[bus.rs2_addr] & ~byp2;
  assign bus.stall = reset & (hz1 | hz2);

endmodule
